// File: rtl/multi_debounce_counter.sv
// multi_debounce_counter
// N independent push-button channels. Each channel has a two-flop
// synchroniser, a stability-window debouncer and a rising-edge detector.
// Each debounced press steps a per-channel up/down counter, which wraps or
// saturates depending on SATURATE. A freezable output register presents
// all counts to the display side.
module multi_debounce_counter #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 4,
    parameter int SATURATE        = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         btn_in,
    input  logic                    dir,
    input  logic                    clear,
    input  logic                    freeze,
    output logic [N_CH-1:0]         btn_level,
    output logic [N_CH-1:0]         press_pulse,
    output logic [N_CH-1:0]         limit_pulse,
    output logic [N_CH*CNT_W-1:0]   cnt_out
);

    localparam int WIN_W = $clog2(DEBOUNCE_CYCLES + 1);

    // The level flips on the cycle the window count would reach
    // DEBOUNCE_CYCLES, i.e. when it already holds DEBOUNCE_CYCLES-1.
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic             sync1_q, sync1_d;
            logic             sync2_q, sync2_d;
            logic [WIN_W-1:0] win_q,   win_d;
            logic             level_q, level_d;
            logic             press_q, press_d;
            logic             limit_q, limit_d;
            logic [CNT_W-1:0] cnt_q,   cnt_d;
            logic [CNT_W-1:0] out_q,   out_d;

            // Next-state logic: synchroniser, debouncer, edge detect, counter, output register
            always_comb begin
                sync1_d = btn_in[gi];
                sync2_d = sync1_q;
                level_d = level_q;
                win_d   = '0;
                if (sync2_q != level_q) begin
                    if (win_q == WIN_LAST) begin
                        level_d = sync2_q;
                    end else begin
                        win_d = win_q + WIN_W'(1);
                    end
                end

                // Press and counter step happen on the same edge the level rises.
                press_d = level_d & ~level_q;

                cnt_d   = cnt_q;
                limit_d = 1'b0;
                if (clear) begin
                    cnt_d = '0;
                end else if (press_d) begin
                    if (dir) begin
                        if (cnt_q == CNT_MAX) begin
                            limit_d = 1'b1;
                            cnt_d   = (SATURATE != 0) ? cnt_q : '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            limit_d = 1'b1;
                            cnt_d   = (SATURATE != 0) ? cnt_q : CNT_MAX;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end

                out_d = freeze ? out_q : cnt_q;
            end

            // State register with asynchronous active-low clear
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    win_q   <= '0;
                    level_q <= 1'b0;
                    press_q <= 1'b0;
                    limit_q <= 1'b0;
                    cnt_q   <= '0;
                    out_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    win_q   <= win_d;
                    level_q <= level_d;
                    press_q <= press_d;
                    limit_q <= limit_d;
                    cnt_q   <= cnt_d;
                    out_q   <= out_d;
                end
            end

            assign btn_level[gi]                 = level_q;
            assign press_pulse[gi]               = press_q;
            assign limit_pulse[gi]               = limit_q;
            assign cnt_out[gi*CNT_W +: CNT_W]    = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_debounce_counter.sv
// Bench for multi_debounce_counter: one wrapping and one saturating instance
// share all stimulus. A press scoreboard checks pulses and counts, a vector
// table checks counts after press bursts, directed sequences cover latency,
// glitches and freeze.
module tb_multi_debounce_counter;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int W  = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   btn_in = '0;
    logic           dir = 1'b1;
    logic           clear = 1'b0;
    logic           freeze = 1'b0;

    logic [N-1:0]   lvl_w, prs_w, lim_w;
    logic [N-1:0]   lvl_s, prs_s, lim_s;
    logic [N*W-1:0] cnt_w, cnt_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_debounce_counter #(.N_CH(N), .DEBOUNCE_CYCLES(D), .CNT_W(W), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .btn_in(btn_in), .dir(dir), .clear(clear), .freeze(freeze),
        .btn_level(lvl_w), .press_pulse(prs_w), .limit_pulse(lim_w), .cnt_out(cnt_w)
    );

    multi_debounce_counter #(.N_CH(N), .DEBOUNCE_CYCLES(D), .CNT_W(W), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .btn_in(btn_in), .dir(dir), .clear(clear), .freeze(freeze),
        .btn_level(lvl_s), .press_pulse(prs_s), .limit_pulse(lim_s), .cnt_out(cnt_s)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: one record per expected press, in channel order per edge.
    typedef struct {
        int ch;
        int cnt_w;
        int cnt_s;
        bit lim_w;
        bit lim_s;
    } sb_t;

    sb_t sb_q[$];

    // Reference counters, one wrapping and one saturating.
    int mw[N];
    int ms[N];

    task automatic push_press(input int ch, input bit d, input bit clr);
        sb_t e;
        e.ch = ch;
        if (clr) begin
            for (int k = 0; k < N; k++) begin
                mw[k] = 0;
                ms[k] = 0;
            end
            e.lim_w = 1'b0;
            e.lim_s = 1'b0;
        end else if (d) begin
            e.lim_w = (mw[ch] == 15);
            e.lim_s = (ms[ch] == 15);
            mw[ch]  = (mw[ch] + 1) % 16;
            ms[ch]  = e.lim_s ? 15 : ms[ch] + 1;
        end else begin
            e.lim_w = (mw[ch] == 0);
            e.lim_s = (ms[ch] == 0);
            mw[ch]  = (mw[ch] + 15) % 16;
            ms[ch]  = e.lim_s ? 0 : ms[ch] - 1;
        end
        e.cnt_w = mw[ch];
        e.cnt_s = ms[ch];
        sb_q.push_back(e);
    endtask

    // Freeze as sampled by the DUT on the most recent rising edge.
    logic frz_s = 1'b0;
    always @(posedge clk) frz_s <= freeze;

    sb_t    pend_e[N];
    bit     pend[N];

    // Monitor: pop on each observed press, check pulses, then the count one edge later.
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < N; c++) pend[c] = 1'b0;
        end else begin
            for (int c = 0; c < N; c++) begin
                if (pend[c]) begin
                    pend[c] = 1'b0;
                    if (!frz_s) begin
                        check($sformatf("sb_cnt_wrap_ch%0d", c), int'(cnt_w[c*W +: W]), pend_e[c].cnt_w);
                        check($sformatf("sb_cnt_sat_ch%0d", c),  int'(cnt_s[c*W +: W]), pend_e[c].cnt_s);
                    end
                end
            end
            for (int c = 0; c < N; c++) begin
                if (prs_w[c]) begin
                    if (sb_q.size() == 0) begin
                        check($sformatf("unexpected_press_ch%0d", c), 1, 0);
                    end else begin
                        sb_t e;
                        e = sb_q.pop_front();
                        $display("press ch%0d exp_ch=%0d lim_w=%0b lim_s=%0b exp_cnt_w=%0d exp_cnt_s=%0d",
                                 c, e.ch, lim_w[c], lim_s[c], e.cnt_w, e.cnt_s);
                        check("sb_channel", c, e.ch);
                        check($sformatf("sb_press_sat_ch%0d", c), int'(prs_s[c]), 1);
                        check($sformatf("sb_limit_wrap_ch%0d", c), int'(lim_w[c]), int'(e.lim_w));
                        check($sformatf("sb_limit_sat_ch%0d", c),  int'(lim_s[c]), int'(e.lim_s));
                        pend_e[c] = e;
                        pend[c]   = 1'b1;
                    end
                end
            end
        end
    end

    // Drive a press on every channel in mask, held for hi cycles, then release.
    task automatic press(input logic [N-1:0] mask, input bit d, input bit clr, input int hi);
        @(negedge clk);
        dir   = d;
        clear = clr;
        if (hi >= D) begin
            for (int c = 0; c < N; c++) if (mask[c]) push_press(c, d, clr);
        end
        btn_in = mask;
        repeat (hi) @(negedge clk);
        btn_in = '0;
        repeat (9) @(negedge clk);
        clear = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] mask;
        bit           d;
        bit           clr;
        int           n;
        int           ch;
        int           exp_w;
        int           exp_s;
    } vec_t;

    vec_t vecs[11];

    initial begin
        for (int k = 0; k < N; k++) begin
            mw[k] = 0;
            ms[k] = 0;
        end

        // Vector table: n presses, then check channel ch in both instances.
        vecs[0]  = '{4'b0100, 1'b1, 1'b0, 15, 2, 15, 15};
        vecs[1]  = '{4'b0100, 1'b1, 1'b0,  1, 2,  0, 15};
        vecs[2]  = '{4'b0100, 1'b0, 1'b0,  1, 2, 15, 14};
        vecs[3]  = '{4'b1000, 1'b1, 1'b0, 16, 3,  0, 15};
        vecs[4]  = '{4'b1000, 1'b1, 1'b0,  1, 3,  1, 15};
        vecs[5]  = '{4'b1000, 1'b0, 1'b0, 15, 3,  2,  0};
        vecs[6]  = '{4'b1000, 1'b0, 1'b0,  1, 3,  1,  0};
        vecs[7]  = '{4'b0011, 1'b1, 1'b0,  1, 0,  2,  2};
        vecs[8]  = '{4'b0000, 1'b1, 1'b0,  0, 1,  2,  2};
        vecs[9]  = '{4'b0001, 1'b1, 1'b1,  1, 0,  0,  0};
        vecs[10] = '{4'b0000, 1'b1, 1'b0,  0, 3,  0,  0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_level", int'(lvl_w | lvl_s), 0);
        check("rst_cnt",   int'(cnt_w | cnt_s), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset pulse in mid-cycle.
        #2 reset = 1'b0;
        #1;
        check("rst_async_pulse", int'(prs_w | lim_w | prs_s | lim_s), 0);
        @(negedge clk);
        reset = 1'b1;

        // Latency: btn_in[0] before E0; level/pulse after E5, cnt_out after E6.
        push_press(0, 1'b1, 1'b0);
        btn_in = 4'b0001;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 4) check("lat_level_E4", int'(lvl_w[0]), 0);
            if (e == 5) begin
                check("lat_level_E5", int'(lvl_w[0]), 1);
                check("lat_press_E5", int'(prs_w[0]), 1);
                check("lat_cnt_E5",   int'(cnt_w[3:0]), 0);
            end
            if (e == 6) begin
                check("lat_cnt_E6",   int'(cnt_w[3:0]), 1);
                check("lat_press_E6", int'(prs_w[0]), 0);
            end
        end
        btn_in = '0;
        repeat (9) @(negedge clk);

        // Glitch rejection: 3-cycle high never registers, 4-cycle high counts once.
        press(4'b0010, 1'b1, 1'b0, 3);
        check("glitch_level", int'(lvl_w[1]), 0);
        check("glitch_cnt",   int'(cnt_w[7:4]), 0);
        press(4'b0010, 1'b1, 1'b0, 4);
        check("glitch4_cnt",  int'(cnt_w[7:4]), 1);

        // Table-driven bursts.
        for (int v = 0; v < 11; v++) begin
            for (int p = 0; p < vecs[v].n; p++) press(vecs[v].mask, vecs[v].d, vecs[v].clr, D + 1);
            check($sformatf("vec%0d_wrap", v), int'(cnt_w[vecs[v].ch*W +: W]), vecs[v].exp_w);
            check($sformatf("vec%0d_sat",  v), int'(cnt_s[vecs[v].ch*W +: W]), vecs[v].exp_s);
        end

        // Freeze: hold 5 across three presses, release exposes 8 one edge later.
        for (int p = 0; p < 5; p++) press(4'b0001, 1'b1, 1'b0, D + 1);
        check("frz_pre", int'(cnt_w[3:0]), 5);
        @(negedge clk);
        freeze = 1'b1;
        for (int p = 0; p < 3; p++) press(4'b0001, 1'b1, 1'b0, D + 1);
        check("frz_hold_wrap", int'(cnt_w[3:0]), 5);
        check("frz_hold_sat",  int'(cnt_s[3:0]), 5);
        freeze = 1'b0;
        @(negedge clk);
        check("frz_release", int'(cnt_w[3:0]), 8);

        repeat (4) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
